// File: rtl/hole_pkg.sv
// hole_pkg: shared constants and FSM encoding for the hole collision scanner.
package hole_pkg;
  localparam int POS_W        = 10;
  localparam int DEF_HOLE_NUM = 8;
  localparam int DEF_IDX_W    = 3;
  localparam int DEF_RADIUS   = 16;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/hole_scan_if.sv
// hole_scan_if: frame-strobe, ball position, hole table and result signals of the scanner.
interface hole_scan_if import hole_pkg::*; #(parameter int IDX_W = DEF_IDX_W);
  logic             i_start;
  logic             i_clear;
  logic [POS_W-1:0] i_bl_x;
  logic [POS_W-1:0] i_bl_y;
  logic [POS_W-1:0] i_hole_x;
  logic [POS_W-1:0] i_hole_y;
  logic [IDX_W-1:0] o_rd_idx;
  logic             o_busy;
  logic             o_done;
  logic             o_fall_in;
  logic [IDX_W-1:0] o_hole_idx;
  modport master (
    output i_start, i_clear, i_bl_x, i_bl_y, i_hole_x, i_hole_y,
    input  o_rd_idx, o_busy, o_done, o_fall_in, o_hole_idx
  );
  modport slave (
    input  i_start, i_clear, i_bl_x, i_bl_y, i_hole_x, i_hole_y,
    output o_rd_idx, o_busy, o_done, o_fall_in, o_hole_idx
  );
endinterface

// File: rtl/dist_sq_cmp.sv
// dist_sq_cmp: two-stage pipeline, stage A absolute differences, stage B squared-distance radius test.
module dist_sq_cmp import hole_pkg::*; #(
  parameter int RADIUS = DEF_RADIUS,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [POS_W-1:0] ax,
  input  logic [POS_W-1:0] ay,
  input  logic [POS_W-1:0] bx,
  input  logic [POS_W-1:0] by,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_hit
);
  localparam int SW = 2*POS_W+1;
  localparam logic [SW-1:0] R2 = SW'(RADIUS*RADIUS);
  logic             a_valid;
  logic [IDX_W-1:0] a_idx;
  logic [POS_W-1:0] dx, dy;
  logic [SW-1:0]    sum;
  always_comb sum = SW'(dx) * SW'(dx) + SW'(dy) * SW'(dy);
  // compare-then-subtract keeps the difference a true magnitude, never a 10-bit wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      a_idx     <= '0;
      dx        <= '0;
      dy        <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_hit   <= 1'b0;
    end else begin
      a_valid   <= in_valid;
      a_idx     <= in_idx;
      dx        <= ax >= bx ? ax - bx : bx - ax;
      dy        <= ay >= by ? ay - by : by - ay;
      out_valid <= a_valid;
      out_idx   <= a_idx;
      out_hit   <= sum <= R2;
    end
  end
endmodule

// File: rtl/hole_scan.sv
// hole_scan: per-frame walk of the hole table, reporting a sticky fall-in flag and the lowest hit index.
module hole_scan import hole_pkg::*; #(
  parameter int HOLE_NUM = DEF_HOLE_NUM,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int RADIUS   = DEF_RADIUS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  hole_scan_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(HOLE_NUM-1);
  state_t           state;
  logic [POS_W-1:0] ball_x, ball_y;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx_q;
  logic             b_valid, b_hit;
  logic [IDX_W-1:0] b_idx;
  logic             fh_valid;
  logic [IDX_W-1:0] fh_idx;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  dist_sq_cmp #(.RADIUS(RADIUS), .IDX_W(IDX_W)) u_dist (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .in_valid (rd_valid),
    .in_idx   (rd_idx_q),
    .ax       (ball_x),
    .ay       (ball_y),
    .bx       (bus.i_hole_x),
    .by       (bus.i_hole_y),
    .out_valid(b_valid),
    .out_idx  (b_idx),
    .out_hit  (b_hit)
  );
  // in DONE the last entry is still sitting in stage B, so fold it in here
  always_comb begin
    hit_any = fh_valid | (b_valid & b_hit);
    hit_idx = fh_valid ? fh_idx : b_idx;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      ball_x         <= '0;
      ball_y         <= '0;
      rd_valid       <= 1'b0;
      rd_idx_q       <= '0;
      fh_valid       <= 1'b0;
      fh_idx         <= '0;
      bus.o_rd_idx   <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_fall_in  <= 1'b0;
      bus.o_hole_idx <= '0;
    end else begin
      rd_valid   <= state == SCAN;
      rd_idx_q   <= bus.o_rd_idx;
      bus.o_done <= 1'b0;
      if (b_valid && b_hit && !fh_valid) begin
        fh_valid <= 1'b1;
        fh_idx   <= b_idx;
      end
      if (bus.i_clear) bus.o_fall_in <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          state        <= SCAN;
          ball_x       <= bus.i_bl_x;
          ball_y       <= bus.i_bl_y;
          bus.o_rd_idx <= '0;
          bus.o_busy   <= 1'b1;
          fh_valid     <= 1'b0;
        end
        SCAN: if (bus.o_rd_idx == LAST) state <= DRAIN;
              else bus.o_rd_idx <= bus.o_rd_idx + 1'b1;
        // rd_valid low means the last entry has left the read stage and is entering stage B
        DRAIN: if (!rd_valid) begin
          state      <= DONE;
          bus.o_done <= 1'b1;
        end
        DONE: begin
          state        <= IDLE;
          bus.o_busy   <= 1'b0;
          bus.o_rd_idx <= '0;
          if (hit_any && !bus.o_fall_in) begin
            bus.o_fall_in  <= 1'b1;
            bus.o_hole_idx <= hit_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hole_scan.sv
// tb_hole_scan: directed and randomized scans checked against a distance-based reference model.
module tb_hole_scan;
  import hole_pkg::*;
  localparam int N = 8;
  localparam int R = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hole_scan_if #(.IDX_W(3)) bus();
  hole_scan #(.HOLE_NUM(N), .IDX_W(3), .RADIUS(R)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );
  logic [9:0] hx [N];
  logic [9:0] hy [N];
  always @(posedge clk) begin
    bus.i_hole_x <= hx[bus.o_rd_idx];
    bus.i_hole_y <= hy[bus.o_rd_idx];
  end
  int errors = 0;
  int checks = 0;
  bit ef = 1'b0;
  int ei = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // lowest hole index whose Euclidean distance from the ball is within R, or -1
  function automatic int first_hit(input int bx, input int by);
    for (int i = 0; i < N; i++) begin
      int dx, dy;
      dx = bx - int'(hx[i]);
      dy = by - int'(hy[i]);
      if (dx*dx + dy*dy <= R*R) return i;
    end
    return -1;
  endfunction
  function automatic int clamp(input int v);
    return v < 0 ? 0 : (v > 1023 ? 1023 : v);
  endfunction
  task automatic set_far();
    for (int i = 0; i < N; i++) begin
      hx[i] = 10'd700;
      hy[i] = 10'd900;
    end
  endtask
  task automatic scan(input int bx, input int by, input bit poke, input bit clr);
    int h;
    h = first_hit(bx, by);
    @(negedge clk);
    bus.i_bl_x  = 10'(bx);
    bus.i_bl_y  = 10'(by);
    bus.i_start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk("busy", bus.o_busy, c <= 11);
      chk("done", bus.o_done, c == 11);
      chk("rd_idx", bus.o_rd_idx, c <= 8 ? c - 1 : (c <= 11 ? 7 : 0));
      if (c == 12) begin
        if (h >= 0 && !ef) begin
          ef = 1'b1;
          ei = h;
        end else if (clr) ef = 1'b0;
        chk("fall_in", bus.o_fall_in, ef);
        chk("hole_idx", bus.o_hole_idx, ei);
      end
      bus.i_start = poke && c == 4;
      bus.i_clear = clr && c == 11;
      bus.i_bl_x  = 10'($urandom);
      bus.i_bl_y  = 10'($urandom);
    end
    bus.i_start = 1'b0;
    bus.i_clear = 1'b0;
  endtask
  task automatic clear_flag();
    @(negedge clk);
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    ef = 1'b0;
    chk("clear", bus.o_fall_in, 0);
    chk("clear_idx", bus.o_hole_idx, ei);
  endtask
  task automatic abort_scan(input int bx, input int by);
    @(negedge clk);
    bus.i_bl_x  = 10'(bx);
    bus.i_bl_y  = 10'(by);
    bus.i_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ef = 1'b0;
    ei = 0;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_fall", bus.o_fall_in, 0);
    chk("rst_idx", bus.o_hole_idx, 0);
    chk("rst_rd", bus.o_rd_idx, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_done", bus.o_done, 0);
      chk("abort_busy", bus.o_busy, 0);
    end
  endtask
  initial begin
    int bx, by;
    bus.i_start = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_bl_x  = '0;
    bus.i_bl_y  = '0;
    set_far();
    repeat (3) @(negedge clk);
    chk("reset_rd", bus.o_rd_idx, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_done", bus.o_done, 0);
    chk("reset_fall", bus.o_fall_in, 0);
    chk("reset_idx", bus.o_hole_idx, 0);
    rst_n = 1'b1;
    hx[3] = 10'd116; hy[3] = 10'd100;
    scan(100, 100, 0, 0);
    chk("edge_fall", bus.o_fall_in, 1);
    chk("edge_idx", bus.o_hole_idx, 3);
    clear_flag();
    hx[3] = 10'd117;
    scan(100, 100, 0, 0);
    chk("outside_fall", bus.o_fall_in, 0);
    set_far();
    hx[0] = 10'd1020; hy[0] = 10'd0;
    scan(0, 0, 0, 0);
    chk("nowrap_fall", bus.o_fall_in, 0);
    set_far();
    hx[2] = 10'd300; hy[2] = 10'd300;
    hx[5] = 10'd300; hy[5] = 10'd300;
    scan(300, 300, 0, 0);
    chk("prio_idx", bus.o_hole_idx, 2);
    set_far();
    hx[6] = 10'd400; hy[6] = 10'd410;
    scan(400, 400, 0, 0);
    chk("sticky_idx", bus.o_hole_idx, 2);
    clear_flag();
    scan(400, 400, 0, 0);
    chk("rehit_idx", bus.o_hole_idx, 6);
    clear_flag();
    set_far();
    scan(200, 200, 1, 0);
    chk("poke_busy", bus.o_busy, 0);
    hx[4] = 10'd50; hy[4] = 10'd60;
    abort_scan(50, 60);
    scan(50, 60, 0, 0);
    chk("after_abort_idx", bus.o_hole_idx, 4);
    clear_flag();
    scan(50, 60, 0, 1);
    chk("clear_vs_set", bus.o_fall_in, 1);
    for (int t = 0; t < 24; t++) begin
      bx = int'($urandom_range(0, 1023));
      by = int'($urandom_range(0, 1023));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          hx[i] = 10'(clamp(bx + int'($urandom_range(0, 40)) - 20));
          hy[i] = 10'(clamp(by + int'($urandom_range(0, 40)) - 20));
        end else begin
          hx[i] = 10'($urandom);
          hy[i] = 10'($urandom);
        end
      end
      scan(bx, by, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) clear_flag();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
